// File: rtl/rf_pkg.sv
// Shared types and helpers for the register-fetch stage with forwarding.
package rf_pkg;

  // Immediate source selector; encoding 3 behaves like IMM_ZERO.
  typedef enum logic [1:0] {
    IMM_U12  = 2'd0,
    IMM_S9   = 2'd1,
    IMM_ZERO = 2'd2
  } imm_sel_t;

  // Where a resolved read operand came from (handy when probing in a waveform).
  typedef enum logic [2:0] {
    FWD_ZERO = 3'd0,
    FWD_EX   = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_WB   = 3'd3,
    FWD_RF   = 3'd4
  } fwd_src_t;

  // Index of the hardwired zero register.
  function automatic int zero_reg(input int nreg);
    return nreg - 1;
  endfunction

endpackage

// File: rtl/regfile_bp.sv
// Two-read/one-write register file with same-cycle WB write-through and a
// hardwired zero register at the top index.
module regfile_bp
  import rf_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREG   = 32,
  parameter int RA_W   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_we,
  input  logic [RA_W-1:0]   i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [RA_W-1:0]   i_raddr_a,
  input  logic [RA_W-1:0]   i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam logic [RA_W-1:0] ZREG = RA_W'(zero_reg(NREG));

  logic [DATA_W-1:0] r_mem [NREG];

  // Array storage: whole file clears on reset; zero-register writes are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != ZREG)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read ports: zero register first, then the in-flight WB value, then storage.
  always_comb begin
    if (i_raddr_a == ZREG)                  o_rdata_a = '0;
    else if (i_we && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
    else                                     o_rdata_a = r_mem[i_raddr_a];

    if (i_raddr_b == ZREG)                  o_rdata_b = '0;
    else if (i_we && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
    else                                     o_rdata_b = r_mem[i_raddr_b];
  end

endmodule

// File: rtl/rf_stage_fwd.sv
// Register-fetch stage: register file read, EX/MEM forwarding, immediate
// selection, load-use hazard detection and the ID/EX pipeline register.
module rf_stage_fwd
  import rf_pkg::*;
#(
  parameter  int DATA_W  = 64,
  parameter  int NREG    = 32,
  parameter  int IMM_W   = 12,
  parameter  int DADDR_W = 9,
  localparam int RA_W    = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               stall_in,
  input  logic               flush,
  input  logic               reg2loc,
  input  logic [1:0]         imm_sel,
  input  logic               alu_src,
  input  logic               set_flag,
  input  logic [RA_W-1:0]    rn,
  input  logic [RA_W-1:0]    rm,
  input  logic [RA_W-1:0]    rd,
  input  logic [IMM_W-1:0]   imm12,
  input  logic [DADDR_W-1:0] daddr9,
  input  logic               wb_we,
  input  logic [RA_W-1:0]    wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               ex_we,
  input  logic [RA_W-1:0]    ex_rd,
  input  logic               ex_is_load,
  input  logic [DATA_W-1:0]  ex_data,
  input  logic               mem_we,
  input  logic [RA_W-1:0]    mem_rd,
  input  logic [DATA_W-1:0]  mem_data,
  output logic               stall_req,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_da,
  output logic [DATA_W-1:0]  out_db,
  output logic [DATA_W-1:0]  out_alu_b,
  output logic [RA_W-1:0]    out_rd,
  output logic               out_set_flag
);

  localparam logic [RA_W-1:0] ZREG = RA_W'(zero_reg(NREG));

  logic [RA_W-1:0]   w_ab;
  logic [DATA_W-1:0] w_rf_a, w_rf_b;
  logic [DATA_W-1:0] w_da, w_db, w_imm, w_alu_b;
  fwd_src_t          w_src_a, w_src_b;

  logic              r_valid;
  logic [DATA_W-1:0] r_da, r_db, r_alu_b;
  logic [RA_W-1:0]   r_rd;
  logic              r_set_flag;

  assign w_ab = reg2loc ? rm : rd;

  regfile_bp #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .RA_W   (RA_W)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_we      (wb_we),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (rn),
    .i_raddr_b (w_ab),
    .o_rdata_a (w_rf_a),
    .o_rdata_b (w_rf_b)
  );

  // Priority: zero reg, EX (never a load in flight), MEM, WB, storage.
  function automatic fwd_src_t sel_src(input logic [RA_W-1:0] addr);
    if (addr == ZREG)                             return FWD_ZERO;
    else if (ex_we && !ex_is_load && ex_rd == addr) return FWD_EX;
    else if (mem_we && mem_rd == addr)            return FWD_MEM;
    else if (wb_we && wb_addr == addr)            return FWD_WB;
    else                                          return FWD_RF;
  endfunction

  // Operand resolution for both read ports; WB write-through lives in the regfile.
  always_comb begin
    w_src_a = sel_src(rn);
    w_src_b = sel_src(w_ab);
    case (w_src_a)
      FWD_ZERO: w_da = '0;
      FWD_EX:   w_da = ex_data;
      FWD_MEM:  w_da = mem_data;
      default:  w_da = w_rf_a;
    endcase
    case (w_src_b)
      FWD_ZERO: w_db = '0;
      FWD_EX:   w_db = ex_data;
      FWD_MEM:  w_db = mem_data;
      default:  w_db = w_rf_b;
    endcase
  end

  // Immediate extension and ALU operand B select.
  always_comb begin
    case (imm_sel)
      IMM_U12: w_imm = {{(DATA_W-IMM_W){1'b0}}, imm12};
      IMM_S9:  w_imm = {{(DATA_W-DADDR_W){daddr9[DADDR_W-1]}}, daddr9};
      default: w_imm = '0;
    endcase
    w_alu_b = alu_src ? w_imm : w_db;
  end

  // Load-use hazard: consumer must wait until the load result reaches MEM.
  assign stall_req = in_valid & ex_we & ex_is_load & (ex_rd != ZREG) &
                     ((ex_rd == rn) | (ex_rd == w_ab));

  // ID/EX register: flush > stall_in > hazard bubble > normal load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid    <= 1'b0;
      r_da       <= '0;
      r_db       <= '0;
      r_alu_b    <= '0;
      r_rd       <= '0;
      r_set_flag <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (stall_in) begin
      r_valid <= r_valid;
    end else if (stall_req) begin
      r_valid <= 1'b0;
    end else begin
      r_valid    <= in_valid;
      r_da       <= w_da;
      r_db       <= w_db;
      r_alu_b    <= w_alu_b;
      r_rd       <= rd;
      r_set_flag <= set_flag;
    end
  end

  assign out_valid    = r_valid;
  assign out_da       = r_da;
  assign out_db       = r_db;
  assign out_alu_b    = r_alu_b;
  assign out_rd       = r_rd;
  assign out_set_flag = r_set_flag;

endmodule

// File: tb/tb_rf_stage_fwd.sv
// Scoreboard bench for rf_stage_fwd: the driver queues hand-computed expected
// ID/EX contents per edge, a monitor pops and compares after each edge.
module tb_rf_stage_fwd;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, stall_in, flush, reg2loc, alu_src, set_flag;
  logic [1:0]  imm_sel;
  logic [4:0]  rn, rm, rd;
  logic [11:0] imm12;
  logic [8:0]  daddr9;
  logic        wb_we, ex_we, ex_is_load, mem_we;
  logic [4:0]  wb_addr, ex_rd, mem_rd;
  logic [63:0] wb_data, ex_data, mem_data;
  logic        stall_req, out_valid, out_set_flag;
  logic [63:0] out_da, out_db, out_alu_b;
  logic [4:0]  out_rd;

  typedef struct packed {
    logic        v;
    logic [63:0] da;
    logic [63:0] db;
    logic [63:0] ab;
    logic [4:0]  rd;
    logic        sf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_txn    = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  rf_stage_fwd dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .stall_in(stall_in),
    .flush(flush), .reg2loc(reg2loc), .imm_sel(imm_sel), .alu_src(alu_src),
    .set_flag(set_flag), .rn(rn), .rm(rm), .rd(rd), .imm12(imm12),
    .daddr9(daddr9), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_data(ex_data),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .stall_req(stall_req), .out_valid(out_valid), .out_da(out_da),
    .out_db(out_db), .out_alu_b(out_alu_b), .out_rd(out_rd),
    .out_set_flag(out_set_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic set_rf(input logic v, input logic [4:0] a_rn, input logic [4:0] a_rm,
                        input logic [4:0] a_rd, input logic r2l, input logic asrc,
                        input logic [1:0] isel, input logic sf);
    in_valid = v; rn = a_rn; rm = a_rm; rd = a_rd;
    reg2loc = r2l; alu_src = asrc; imm_sel = isel; set_flag = sf;
  endtask

  task automatic set_fwd(input logic exw, input logic [4:0] exr, input logic exl,
                         input logic [63:0] exd, input logic mw, input logic [4:0] mr,
                         input logic [63:0] md, input logic ww, input logic [4:0] wa,
                         input logic [63:0] wd);
    ex_we = exw; ex_rd = exr; ex_is_load = exl; ex_data = exd;
    mem_we = mw; mem_rd = mr; mem_data = md;
    wb_we = ww; wb_addr = wa; wb_data = wd;
  endtask

  task automatic expect_out(input logic v, input logic [63:0] da, input logic [63:0] db,
                            input logic [63:0] ab, input logic [4:0] erd, input logic sf);
    exp_t e;
    e.v = v; e.da = da; e.db = db; e.ab = ab; e.rd = erd; e.sf = sf;
    exp_q.push_back(e);
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0b, expected %0b", name, act, req);
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: compare one queued expectation after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_txn++;
      n_checks++;
      if (out_valid === e.v && out_da === e.da && out_db === e.db &&
          out_alu_b === e.ab && out_rd === e.rd && out_set_flag === e.sf) begin
        n_pass++;
        $display("txn %0d ok: v=%0b da=%h db=%h alu_b=%h rd=%0d sf=%0b",
                 n_txn, out_valid, out_da, out_db, out_alu_b, out_rd, out_set_flag);
      end else begin
        $display("FAIL txn %0d: got v=%0b da=%h db=%h alu_b=%h rd=%0d sf=%0b, expected v=%0b da=%h db=%h alu_b=%h rd=%0d sf=%0b",
                 n_txn, out_valid, out_da, out_db, out_alu_b, out_rd, out_set_flag,
                 e.v, e.da, e.db, e.ab, e.rd, e.sf);
      end
    end
  end

  initial begin
    reset_n = 1'b0; stall_in = 1'b0; flush = 1'b0;
    imm12 = '0; daddr9 = '0;
    set_rf(0, 0, 0, 0, 0, 0, 2, 0);
    set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk1("reset_valid", out_valid, 1'b0);
    chk64("reset_da", out_da, 64'h0);
    chk64("reset_alu_b", out_alu_b, 64'h0);
    @(negedge clk); reset_n = 1'b1;

    // V1: WB write X5 with same-cycle read; rm=X31 reads zero.
    @(negedge clk);
    set_fwd(0, 0, 0, 0, 0, 0, 0, 1, 5, 64'h1234);
    set_rf(1, 5, 31, 2, 1, 0, 2, 1);
    expect_out(1, 64'h1234, 64'h0, 64'h0, 2, 1);
    // V2: write to X31 ignored; X5 now from storage.
    @(negedge clk);
    set_fwd(0, 0, 0, 0, 0, 0, 0, 1, 31, 64'hDEAD);
    set_rf(1, 31, 5, 4, 1, 0, 2, 0);
    expect_out(1, 64'h0, 64'h1234, 64'h1234, 4, 0);
    // V3: EX beats MEM on X3; port B reads rd=X5.
    @(negedge clk);
    set_fwd(1, 3, 0, 64'hAA, 1, 3, 64'hBB, 0, 0, 0);
    set_rf(1, 3, 0, 5, 0, 0, 2, 0);
    expect_out(1, 64'hAA, 64'h1234, 64'h1234, 5, 0);
    // V4: EX off, MEM forwards to both ports.
    @(negedge clk);
    set_fwd(0, 3, 0, 64'hAA, 1, 3, 64'hBB, 0, 0, 0);
    set_rf(1, 3, 0, 3, 0, 0, 2, 0);
    expect_out(1, 64'hBB, 64'hBB, 64'hBB, 3, 0);
    // V5: MEM beats WB on X6 (X6 still written 0x77); imm12=0xFFF zero-extended.
    @(negedge clk);
    set_fwd(0, 0, 0, 0, 1, 6, 64'h66, 1, 6, 64'h77);
    set_rf(1, 6, 31, 6, 1, 1, 0, 0);
    imm12 = 12'hFFF;
    expect_out(1, 64'h66, 64'h0, 64'hFFF, 6, 0);
    // V6: EX targeting X31 does not override zero; daddr9=0x1FF sign-extends.
    @(negedge clk);
    set_fwd(1, 31, 0, 64'h99, 0, 0, 0, 0, 0, 0);
    set_rf(1, 31, 6, 7, 1, 1, 1, 0);
    daddr9 = 9'h1FF;
    expect_out(1, 64'h0, 64'h77, ONES, 7, 0);
    // V7: positive daddr9.
    @(negedge clk);
    set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_rf(1, 5, 6, 8, 1, 1, 1, 1);
    daddr9 = 9'h0FF;
    expect_out(1, 64'h1234, 64'h77, 64'hFF, 8, 1);
    // V8: imm_sel=3 acts as zero.
    @(negedge clk);
    set_rf(1, 31, 31, 9, 1, 1, 3, 0);
    imm12 = 12'hABC;
    expect_out(1, 64'h0, 64'h0, 64'h0, 9, 0);
    // V9: load-use via rm -> stall_req, bubble, data held.
    @(negedge clk);
    set_fwd(1, 7, 1, 64'h55, 0, 0, 0, 0, 0, 0);
    set_rf(1, 0, 7, 10, 1, 0, 2, 1);
    #1 chk1("stall_req_rm_hit", stall_req, 1'b1);
    expect_out(0, 64'h0, 64'h0, 64'h0, 9, 0);
    // V10: reg2loc=0, rd=8 -> no hazard.
    @(negedge clk);
    set_rf(1, 5, 7, 8, 0, 0, 2, 1);
    #1 chk1("stall_req_rd_miss", stall_req, 1'b0);
    expect_out(1, 64'h1234, 64'h0, 64'h0, 8, 1);
    // V11: in_valid=0 -> no stall; the EX load value is not forwarded.
    @(negedge clk);
    set_rf(0, 7, 6, 11, 1, 0, 2, 0);
    #1 chk1("stall_req_invalid", stall_req, 1'b0);
    expect_out(0, 64'h0, 64'h77, 64'h77, 11, 0);
    // V12: load data now arrives via MEM.
    @(negedge clk);
    set_fwd(0, 0, 0, 0, 1, 7, 64'h55, 0, 0, 0);
    set_rf(1, 7, 5, 12, 1, 0, 2, 1);
    expect_out(1, 64'h55, 64'h1234, 64'h1234, 12, 1);
    // V13: load into X31 never stalls.
    @(negedge clk);
    set_fwd(1, 31, 1, 64'h11, 0, 0, 0, 0, 0, 0);
    set_rf(1, 31, 6, 13, 1, 0, 2, 0);
    #1 chk1("stall_req_zero_reg", stall_req, 1'b0);
    expect_out(1, 64'h0, 64'h77, 64'h77, 13, 0);
    // V14: load a valid entry, then hold it for 3 stall cycles.
    @(negedge clk);
    set_fwd(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_rf(1, 5, 6, 9, 1, 0, 2, 1);
    expect_out(1, 64'h1234, 64'h77, 64'h77, 9, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stall_in = 1'b1;
      set_rf(1, 6, 5, 5'(10 + k), 0, k[0], 2, 0);
      expect_out(1, 64'h1234, 64'h77, 64'h77, 9, 1);
    end
    // Flush wins over stall_in.
    @(negedge clk);
    flush = 1'b1;
    expect_out(0, 64'h1234, 64'h77, 64'h77, 9, 1);
    // V19: normal load resumes.
    @(negedge clk);
    flush = 1'b0; stall_in = 1'b0;
    set_rf(1, 6, 5, 3, 1, 0, 2, 0);
    expect_out(1, 64'h77, 64'h1234, 64'h1234, 3, 0);

    // Asynchronous reset in mid-cycle while holding a valid entry.
    @(negedge clk);
    stall_in = 1'b1;
    #2;
    chk1("pre_reset_valid", out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("async_reset_valid", out_valid, 1'b0);
    chk64("async_reset_da", out_da, 64'h0);
    chk64("async_reset_db", out_db, 64'h0);
    chk64("async_reset_alu_b", out_alu_b, 64'h0);
    @(negedge clk);
    reset_n = 1'b1; stall_in = 1'b0;
    // Register file cleared: X5, X6 and X7 read 0.
    @(negedge clk);
    set_rf(1, 5, 6, 1, 1, 0, 2, 0);
    expect_out(1, 64'h0, 64'h0, 64'h0, 1, 0);
    @(negedge clk);
    set_rf(1, 7, 0, 6, 0, 0, 2, 1);
    expect_out(1, 64'h0, 64'h0, 64'h0, 6, 1);
    @(negedge clk);
    set_rf(0, 0, 0, 0, 0, 0, 2, 0);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
